pc_call_stack: RTL
==================

PC_CALL_STACK -- requirements
Module: pc_call_stack

Interface
REQ-001 The block SHALL have parameter AW, default 12, giving the program-counter width in bits.
REQ-002 The block SHALL have parameter DW, default 17, giving the width of datain; only datain[AW-1:0] is used.
REQ-003 The block SHALL have parameter DEPTH, default 8, giving return-stack entries (power of 2, >=2).
REQ-004 The block SHALL have port clk  input  1  system clock, rising-edge active.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port clr_en  input  1  clears the PC and empties the stack.
REQ-007 The block SHALL have port ret_en  input  1  pops the stack into the PC.
REQ-008 The block SHALL have port call_en  input  1  pushes dataout+1, then jumps to datain.
REQ-009 The block SHALL have port write_en  input  1  jumps to datain (no push).
REQ-010 The block SHALL have port br_en  input  1  adds offset to the PC.
REQ-011 The block SHALL have port inc_en  input  1  increments the PC by 1.
REQ-012 The block SHALL have port datain  input  DW  jump/call target.
REQ-013 The block SHALL have port offset  input  AW  two's-complement branch displacement.
REQ-014 The block SHALL have port err_clr  input  1  clears the sticky error flags.
REQ-015 The block SHALL have port dataout  output  AW  current PC, registered.
REQ-016 The block SHALL have port count  output  $clog2(DEPTH)+1  stack occupancy.
REQ-017 The block SHALL have ports full and empty  output  1 each  flags for count==DEPTH and count==0.
REQ-018 The block SHALL have ports ovf_err and unf_err  output  1 each  sticky overflow/underflow flags.

Function
REQ-019 At most one operation SHALL take effect per rising edge, priority clr > ret > call > write > br > inc; lower-priority requests in that cycle SHALL be discarded without error.
REQ-020 All results SHALL be visible on dataout and count one clock after the requesting edge; full and empty SHALL be combinational decodes of registered count.
REQ-021 clr SHALL set dataout=0 and count=0, and SHALL leave the error flags unchanged.
REQ-022 ret with count>0 SHALL load the top entry into dataout and decrement count; ret with count==0 SHALL leave dataout and count unchanged and set unf_err.
REQ-023 call with count<DEPTH SHALL push (dataout+1) mod 2^AW, load datain[AW-1:0] and increment count; call with count==DEPTH SHALL leave dataout, count and stack unchanged and set ovf_err.
REQ-024 write SHALL load datain[AW-1:0] into dataout.
REQ-025 br SHALL load (dataout+offset) mod 2^AW into dataout.
REQ-026 inc SHALL load (dataout+1) mod 2^AW into dataout, so 2^AW-1 wraps to 0.
REQ-027 With no request active, all state SHALL hold.
REQ-028 Error flags SHALL remain set until err_clr or reset; if err_clr and a new error occur in the same cycle, the flag SHALL end set.

Reset
REQ-029 rst_n low SHALL immediately, without a clock, force dataout=0, count=0, ovf_err=0 and unf_err=0, including mid-operation.
REQ-030 Stack storage SHALL NOT be reset; stale entries SHALL be unobservable because count=0.

Structure
REQ-031 Shared package pc_pkg SHALL hold the op-priority enum (OP_NONE, OP_INC, OP_BR, OP_WRITE, OP_CALL, OP_RET, OP_CLR) and the default AW/DW/DEPTH constants.
REQ-032 The return stack SHALL be sub-module ras_lifo (push, pop, top, count, full, empty), instantiated once.

Verification (AW=12, DEPTH=4)
REQ-033 Bench SHALL cover reset mid-operation: inc for 5 cycles -> dataout=5; drop rst_n between edges -> dataout=0 and count=0 before the next edge.
REQ-034 Bench SHALL cover wrap-around: write 0xFFF, then inc -> 0x000; from 0x001, br offset=0xFFE -> 0xFFF.
REQ-035 Bench SHALL cover call/return: PC=0x010, call datain=0x200 -> 0x200 and count=1; ret -> 0x011, count=0 and empty=1.
REQ-036 Bench SHALL cover overflow: 4 calls -> full=1; a 5th call -> PC unchanged, count=4, ovf_err=1; err_clr -> ovf_err=0.
REQ-037 Bench SHALL cover underflow: ret at count=0 -> PC unchanged and unf_err=1.
REQ-038 Bench SHALL cover priority: count=2 with clr, ret and inc together -> dataout=0 and count=0; with ret and call together -> only the pop occurs.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared operation encoding, priority decode and default sizes for the PC call stack
package pc_pkg;
  localparam int AW_DEF = 12;
  localparam int DW_DEF = 17;
  localparam int DEPTH_DEF = 8;
  typedef enum logic [2:0] {OP_NONE, OP_INC, OP_BR, OP_WRITE, OP_CALL, OP_RET, OP_CLR} op_t;
  function automatic op_t op_sel(input logic clr, ret, call, wr, br, inc);
    return clr ? OP_CLR : ret ? OP_RET : call ? OP_CALL : wr ? OP_WRITE : br ? OP_BR : inc ? OP_INC : OP_NONE;
  endfunction
endpackage

// File: rtl/ras_lifo.sv
// ras_lifo: return-address LIFO; storage is unreset, occupancy alone hides stale entries
module ras_lifo #(
  parameter int W = 12,
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_idx, rd_idx;
  logic do_push, do_pop;
  assign wr_idx = count[PW-1:0];
  assign rd_idx = wr_idx - PW'(1);
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full && !clr;
  assign do_pop = pop && !empty && !clr && !push;
  assign top = mem[rd_idx];
  always_ff @(posedge clk)
    if (do_push) mem[wr_idx] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= clr ? '0 : do_push ? count + CW'(1) : do_pop ? count - CW'(1) : count;
endmodule

// File: rtl/pc_call_stack.sv
// pc_call_stack: program counter with prioritised inc/branch/jump/call/return/clear and sticky stack errors
module pc_call_stack
  import pc_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_en,
  input  logic                   ret_en,
  input  logic                   call_en,
  input  logic                   write_en,
  input  logic                   br_en,
  input  logic                   inc_en,
  input  logic [DW-1:0]          datain,
  input  logic [AW-1:0]          offset,
  input  logic                   err_clr,
  output logic [AW-1:0]          dataout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   ovf_err,
  output logic                   unf_err
);
  op_t op;
  logic [AW-1:0] pc_next, ras_top, jmp, pc_inc;
  logic ovf_set, unf_set;
  assign op = op_sel(clr_en, ret_en, call_en, write_en, br_en, inc_en);
  assign jmp = AW'(datain);
  assign pc_inc = dataout + AW'(1);
  assign ovf_set = op == OP_CALL && full;
  assign unf_set = op == OP_RET && empty;
  ras_lifo #(.W(AW), .DEPTH(DEPTH)) u_ras (
    .clk(clk), .rst_n(rst_n), .clr(op == OP_CLR), .push(op == OP_CALL), .pop(op == OP_RET),
    .din(pc_inc), .top(ras_top), .count(count), .full(full), .empty(empty)
  );
  always_comb
    pc_next = op == OP_CLR ? '0 :
              op == OP_RET ? (empty ? dataout : ras_top) :
              op == OP_CALL ? (full ? dataout : jmp) :
              op == OP_WRITE ? jmp :
              op == OP_BR ? dataout + offset :
              op == OP_INC ? pc_inc : dataout;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dataout <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      dataout <= pc_next;
      ovf_err <= ovf_set | (ovf_err & ~err_clr);
      unf_err <= unf_set | (unf_err & ~err_clr);
    end
endmodule
